udp_rx_payload_extractor: RTL and testbench

Receive-side counterpart of the UDP transmit path.
- Consumes the byte stream of a received Ethernet frame, after the RMII-to-byte and preamble/SFD stripping stage and with FCS already removed.
- Filters on destination MAC, ethertype, IPv4 protocol and UDP destination port.
- Re-packs the UDP payload into 16-bit big-endian words for the application, such as the test-pattern sink on the remote board.

---
 rtl/net_pkg.sv | 25 ++
 rtl/udp_word_packer.sv | 44 ++++
 rtl/udp_rx_payload_extractor.sv | 160 ++++++++++++++++
 tb/tb_udp_rx_payload_extractor.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/net_pkg.sv
// rtl/net_pkg.sv - shared constants, header offsets and receive FSM state type
// Used by udp_rx_payload_extractor and udp_word_packer.
package net_pkg;

  localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
  localparam logic [7:0]  IPV4_VER_IHL   = 8'h45;
  localparam logic [7:0]  IP_PROTO_UDP   = 8'h11;
  localparam logic [47:0] BCAST_MAC      = 48'hFFFF_FFFF_FFFF;

  localparam logic [5:0] OFF_ETYPE = 6'd12;
  localparam logic [5:0] OFF_VIHL  = 6'd14;
  localparam logic [5:0] OFF_PROTO = 6'd23;
  localparam logic [5:0] OFF_DPORT = 6'd36;
  localparam logic [5:0] OFF_ULEN  = 6'd38;
  localparam logic [5:0] HDR_BYTES = 6'd42;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    PAYLOAD,
    DROP,
    FLUSH
  } rx_state_t;

endpackage

// File: rtl/udp_word_packer.sv
// rtl/udp_word_packer.sv - packs payload bytes into big-endian 16-bit words
// A flush emits any pending byte as {pending, 8'h00}, or a lone input byte as {byte, 8'h00}.
module udp_word_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid_i,
  input  logic [7:0]  in_byte_i,
  input  logic        flush_i,
  output logic        axiov_o,
  output logic [15:0] axiod_o
);

  logic       pend_valid_q;
  logic [7:0] pend_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_valid_q <= 1'b0;
      pend_q       <= 8'h00;
      axiov_o      <= 1'b0;
      axiod_o      <= 16'h0000;
    end else begin
      axiov_o <= 1'b0;
      if (in_valid_i) begin
        if (pend_valid_q) begin
          axiov_o      <= 1'b1;
          axiod_o      <= {pend_q, in_byte_i};
          pend_valid_q <= 1'b0;
        end else if (flush_i) begin
          axiov_o <= 1'b1;
          axiod_o <= {in_byte_i, 8'h00};
        end else begin
          pend_q       <= in_byte_i;
          pend_valid_q <= 1'b1;
        end
      end else if (flush_i && pend_valid_q) begin
        axiov_o      <= 1'b1;
        axiod_o      <= {pend_q, 8'h00};
        pend_valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/udp_rx_payload_extractor.sv
// rtl/udp_rx_payload_extractor.sv - filters received Ethernet/IPv4/UDP frames and extracts payload words
// Optional UDP_LEN_TRIM_EN: limit payload to udp_len-8 bytes, discarding Ethernet padding.
module udp_rx_payload_extractor
  import net_pkg::*;
#(
  parameter int DATA_SIZE = 16,
  parameter int HDR_LEN   = 42
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 axiiv,
  input  logic [7:0]           axiid,
  input  logic [47:0]          mac,
  input  logic [15:0]          udp_port_in,
  output logic                 axiov,
  output logic [DATA_SIZE-1:0] axiod,
  output logic                 frame_done,
  output logic                 frame_drop
);

  localparam logic [5:0] HDR_LAST = 6'(HDR_LEN - 1);

  rx_state_t   state_q;
  logic [5:0]  cnt_q;
  logic        first_q;
  logic [5:0]  off;
  logic [7:0]  mac_byte;
  logic        hdr_ok;
  logic        pk_valid;
  logic        pk_flush;
  logic [15:0] pk_axiod;

`ifdef UDP_LEN_TRIM_EN
  logic [15:0] ulen_q;
  logic [15:0] pay_cnt_q;
  logic [15:0] limit;

  assign limit    = ulen_q - 16'd8;
  assign pk_valid = (state_q == PAYLOAD) && axiiv && (pay_cnt_q < limit);
  // Emit the final word as soon as the last counted byte arrives; padding is ignored.
  assign pk_flush = (state_q == PAYLOAD) &&
                    (!axiiv || (pk_valid && (pay_cnt_q == limit - 16'd1)));
`else
  assign pk_valid = (state_q == PAYLOAD) && axiiv;
  assign pk_flush = (state_q == PAYLOAD) && !axiiv;
`endif

  always_comb begin
    off = (state_q == IDLE) ? 6'd0 : cnt_q;
    case (off[2:0])
      3'd0:    mac_byte = mac[47:40];
      3'd1:    mac_byte = mac[39:32];
      3'd2:    mac_byte = mac[31:24];
      3'd3:    mac_byte = mac[23:16];
      3'd4:    mac_byte = mac[15:8];
      3'd5:    mac_byte = mac[7:0];
      default: mac_byte = 8'h00;
    endcase
    hdr_ok = 1'b1;
    if (off < 6'd6) begin
      hdr_ok = (axiid == mac_byte) || (axiid == BCAST_MAC[7:0]);
    end else begin
      case (off)
        OFF_ETYPE:         hdr_ok = (axiid == ETHERTYPE_IPV4[15:8]);
        OFF_ETYPE + 6'd1:  hdr_ok = (axiid == ETHERTYPE_IPV4[7:0]);
        OFF_VIHL:          hdr_ok = (axiid == IPV4_VER_IHL);
        OFF_PROTO:         hdr_ok = (axiid == IP_PROTO_UDP);
        OFF_DPORT:         hdr_ok = (axiid == udp_port_in[15:8]);
        OFF_DPORT + 6'd1:  hdr_ok = (axiid == udp_port_in[7:0]);
`ifdef UDP_LEN_TRIM_EN
        OFF_ULEN + 6'd1:   hdr_ok = ({ulen_q[15:8], axiid} >= 16'd8);
`endif
        default:           hdr_ok = 1'b1;
      endcase
    end
  end

  // first_q catches a frame already in flight when reset releases.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= 6'd0;
      first_q    <= 1'b1;
      frame_done <= 1'b0;
      frame_drop <= 1'b0;
`ifdef UDP_LEN_TRIM_EN
      ulen_q     <= 16'd0;
      pay_cnt_q  <= 16'd0;
`endif
    end else begin
      first_q    <= 1'b0;
      frame_done <= 1'b0;
      frame_drop <= 1'b0;
      case (state_q)
        IDLE: begin
          if (axiiv) begin
            cnt_q <= 6'd1;
            if (first_q)      state_q <= FLUSH;
            else if (!hdr_ok) state_q <= DROP;
            else              state_q <= HDR;
          end
        end
        HDR: begin
          if (!axiiv) begin
            frame_drop <= 1'b1;
            state_q    <= IDLE;
            cnt_q      <= 6'd0;
          end else if (!hdr_ok) begin
            state_q <= DROP;
          end else begin
            if (cnt_q != HDR_BYTES) cnt_q <= cnt_q + 6'd1;
            if (cnt_q == HDR_LAST)  state_q <= PAYLOAD;
`ifdef UDP_LEN_TRIM_EN
            if (cnt_q == OFF_ULEN)        ulen_q[15:8] <= axiid;
            if (cnt_q == OFF_ULEN + 6'd1) ulen_q[7:0]  <= axiid;
            pay_cnt_q <= 16'd0;
`endif
          end
        end
        PAYLOAD: begin
          if (!axiiv) begin
            frame_done <= 1'b1;
            state_q    <= IDLE;
            cnt_q      <= 6'd0;
          end
`ifdef UDP_LEN_TRIM_EN
          if (pk_valid) pay_cnt_q <= pay_cnt_q + 16'd1;
`endif
        end
        DROP: begin
          if (!axiiv) begin
            frame_drop <= 1'b1;
            state_q    <= IDLE;
            cnt_q      <= 6'd0;
          end
        end
        FLUSH: begin
          if (!axiiv) begin
            state_q <= IDLE;
            cnt_q   <= 6'd0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  udp_word_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .in_valid_i (pk_valid),
    .in_byte_i  (axiid),
    .flush_i    (pk_flush),
    .axiov_o    (axiov),
    .axiod_o    (pk_axiod)
  );

  assign axiod = pk_axiod;

endmodule

// File: tb/tb_udp_rx_payload_extractor.sv
// tb/tb_udp_rx_payload_extractor.sv - scoreboard bench for udp_rx_payload_extractor
// Honours UDP_LEN_TRIM_EN in its reference model.
module tb_udp_rx_payload_extractor;

  typedef struct packed {
    logic [1:0]  kind;   // 1 word, 2 done, 3 drop
    logic [15:0] data;
    logic [31:0] cyc;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        axiiv;
  logic [7:0]  axiid;
  logic [47:0] mac;
  logic [15:0] udp_port_in;
  logic        axiov;
  logic [15:0] axiod;
  logic        frame_done;
  logic        frame_drop;

  int  cyc = 0;
  int  n_asrt = 0;
  int  n_fail = 0;
  ev_t exp_q[$];
  ev_t obs_q[$];
  ev_t e, o;

  udp_rx_payload_extractor dut (
    .clk         (clk),
    .rst         (rst),
    .axiiv       (axiiv),
    .axiid       (axiid),
    .mac         (mac),
    .udp_port_in (udp_port_in),
    .axiov       (axiov),
    .axiod       (axiod),
    .frame_done  (frame_done),
    .frame_drop  (frame_drop)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (axiov)      obs_q.push_back('{kind: 2'd1, data: axiod, cyc: 32'(cyc)});
    if (frame_done) obs_q.push_back('{kind: 2'd2, data: 16'h0, cyc: 32'(cyc)});
    if (frame_drop) obs_q.push_back('{kind: 2'd3, data: 16'h0, cyc: 32'(cyc)});
  end

  task automatic build(input logic [47:0] dmac, input logic [15:0] dport, input logic [15:0] ulen,
                       input logic [7:0] pay[$], output logic [7:0] f[$]);
    logic [15:0] tl;
    tl = ulen + 16'd20;
    f = {};
    for (int i = 0; i < 6; i++) f.push_back(dmac[8*(5-i) +: 8]);
    f = {f, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h08, 8'h00, 8'h45, 8'h00, tl[15:8], tl[7:0],
         8'h00, 8'h00, 8'h00, 8'h00, 8'h40, 8'h11, 8'h00, 8'h00, 8'hC0, 8'hA8, 8'h01, 8'h02,
         8'hC0, 8'hA8, 8'h01, 8'h03, 8'h12, 8'h34, dport[15:8], dport[7:0], ulen[15:8], ulen[7:0],
         8'h00, 8'h00};
    f = {f, pay};
  endtask

  // Reference model: walks the bytes and queues the events the DUT should produce.
  task automatic push_expected(input logic [7:0] f[$], input int n, input int start);
    bit ok = 1'b1;
    int plen, eff, fin;
    for (int i = 0; i < n && i < 42; i++) begin
      case (i)
        0, 1, 2, 3, 4, 5: if (f[i] != mac[8*(5-i) +: 8] && f[i] != 8'hFF) ok = 1'b0;
        12: if (f[i] != 8'h08) ok = 1'b0;
        13: if (f[i] != 8'h00) ok = 1'b0;
        14: if (f[i] != 8'h45) ok = 1'b0;
        23: if (f[i] != 8'h11) ok = 1'b0;
        36: if (f[i] != udp_port_in[15:8]) ok = 1'b0;
        37: if (f[i] != udp_port_in[7:0]) ok = 1'b0;
`ifdef UDP_LEN_TRIM_EN
        39: if ({f[38], f[39]} < 16'd8) ok = 1'b0;
`endif
        default: ;
      endcase
    end
    fin = start + n + 1;
    if (!ok || n < 42) begin
      exp_q.push_back('{kind: 2'd3, data: 16'h0, cyc: 32'(fin)});
      return;
    end
    plen = n - 42;
    eff  = plen;
`ifdef UDP_LEN_TRIM_EN
    if (int'({f[38], f[39]}) - 8 < eff) eff = int'({f[38], f[39]}) - 8;
`endif
    for (int k = 0; k + 1 < eff; k += 2)
      exp_q.push_back('{kind: 2'd1, data: {f[42+k], f[43+k]}, cyc: 32'(start + 44 + k)});
    if (eff % 2 == 1)
      exp_q.push_back('{kind: 2'd1, data: {f[42+eff-1], 8'h00},
                        cyc: 32'((eff < plen) ? start + 42 + eff : fin)});
    exp_q.push_back('{kind: 2'd2, data: 16'h0, cyc: 32'(fin)});
  endtask

  task automatic run_frame(input logic [7:0] f[$], input int n);
    int start;
    @(posedge clk); #1;
    start = cyc;
    push_expected(f, n, start);
    for (int i = 0; i < n; i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      axiiv = 1'b1;
      axiid = f[i];
    end
    @(posedge clk); #1;
    axiiv = 1'b0;
    axiid = 8'h00;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; axiiv = 1'b0; axiid = 8'h00;
    mac = 48'h42_04_20_42_04_20;
    udp_port_in = 16'hA455;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_asrt++; if (axiov !== 1'b0) begin n_fail++; $display("FAIL reset_axiov: got %b want 0", axiov); end
    n_asrt++; if (axiod !== 16'h0) begin n_fail++; $display("FAIL reset_axiod: got %h want 0000", axiod); end
    n_asrt++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", frame_done); end
    n_asrt++; if (frame_drop !== 1'b0) begin n_fail++; $display("FAIL reset_drop: got %b want 0", frame_drop); end
    obs_q.delete();
  endtask

  task automatic test_filters;
    logic [7:0] f[$];
    logic [7:0] p[$];
    p = {8'hAB, 8'hCD, 8'h69, 8'h69, 8'hFF, 8'hFF, 8'h04, 8'h20};
    build(48'hFFFF_FFFF_FFFF, 16'hA455, 16'd16, p, f);  run_frame(f, f.size());
    build(48'hFFFF_FFFF_FFFF, 16'hA456, 16'd16, p, f);  run_frame(f, f.size());
    build(48'h42_04_20_42_04_21, 16'hA455, 16'd16, p, f); run_frame(f, f.size());
    build(48'h42_04_20_42_04_20, 16'hA455, 16'd16, p, f); run_frame(f, f.size());
    p = {8'hAB, 8'hCD, 8'h69};
    build(48'hFFFF_FFFF_FFFF, 16'hA455, 16'd11, p, f);  run_frame(f, f.size());
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_asrt++;
      o = (obs_q.size() > 0) ? obs_q.pop_front() : '0;
      if (o !== e) begin
        n_fail++;
        $display("FAIL filters: got kind=%0d data=%h cyc=%0d want kind=%0d data=%h cyc=%0d",
                 o.kind, o.data, o.cyc, e.kind, e.data, e.cyc);
      end
    end
    n_asrt++;
    if (obs_q.size() !== 0) begin n_fail++; $display("FAIL filters_extra: got %0d events want 0", obs_q.size()); end
    obs_q.delete();
  endtask

  task automatic test_runt;
    logic [7:0] f[$];
    logic [7:0] p[$];
    p = {8'h11, 8'h22, 8'h33, 8'h44};
    build(48'h42_04_20_42_04_20, 16'hA455, 16'd12, p, f);
    run_frame(f, 30);
    run_frame(f, f.size());
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_asrt++;
      o = (obs_q.size() > 0) ? obs_q.pop_front() : '0;
      if (o !== e) begin
        n_fail++;
        $display("FAIL runt: got kind=%0d data=%h cyc=%0d want kind=%0d data=%h cyc=%0d",
                 o.kind, o.data, o.cyc, e.kind, e.data, e.cyc);
      end
    end
    n_asrt++;
    if (obs_q.size() !== 0) begin n_fail++; $display("FAIL runt_extra: got %0d events want 0", obs_q.size()); end
    obs_q.delete();
  endtask

  task automatic test_reset_mid;
    logic [7:0] f[$];
    logic [7:0] p[$];
    p = {8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    build(48'hFFFF_FFFF_FFFF, 16'hA455, 16'd18, p, f);
    @(posedge clk); #1;
    for (int i = 0; i < f.size(); i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      axiiv = 1'b1;
      axiid = f[i];
      rst   = (i == 47);
      if (i == 48) begin
        obs_q.delete();
        n_asrt++;
        if (axiov !== 1'b0 || axiod !== 16'h0) begin
          n_fail++; $display("FAIL midrst_out: got axiov=%b axiod=%h want 0 0000", axiov, axiod);
        end
      end
    end
    @(posedge clk); #1;
    axiiv = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_asrt++;
    if (obs_q.size() !== 0) begin n_fail++; $display("FAIL midrst_quiet: got %0d events want 0", obs_q.size()); end
    obs_q.delete();
    run_frame(f, f.size());
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_asrt++;
      o = (obs_q.size() > 0) ? obs_q.pop_front() : '0;
      if (o !== e) begin
        n_fail++;
        $display("FAIL midrst_next: got kind=%0d data=%h cyc=%0d want kind=%0d data=%h cyc=%0d",
                 o.kind, o.data, o.cyc, e.kind, e.data, e.cyc);
      end
    end
    n_asrt++;
    if (obs_q.size() !== 0) begin n_fail++; $display("FAIL midrst_extra: got %0d events want 0", obs_q.size()); end
    obs_q.delete();
  endtask

  task automatic test_padding;
    logic [7:0] f[$];
    logic [7:0] p[$];
    p = {8'hAB, 8'hCD};
    for (int i = 0; i < 16; i++) p.push_back(8'h00);
    build(48'hFFFF_FFFF_FFFF, 16'hA455, 16'h000A, p, f);
    run_frame(f, f.size());
    p = {8'h5A};
    for (int i = 0; i < 17; i++) p.push_back(8'hEE);
    build(48'hFFFF_FFFF_FFFF, 16'hA455, 16'h0009, p, f);
    run_frame(f, f.size());
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_asrt++;
      o = (obs_q.size() > 0) ? obs_q.pop_front() : '0;
      if (o !== e) begin
        n_fail++;
        $display("FAIL padding: got kind=%0d data=%h cyc=%0d want kind=%0d data=%h cyc=%0d",
                 o.kind, o.data, o.cyc, e.kind, e.data, e.cyc);
      end
    end
    n_asrt++;
    if (obs_q.size() !== 0) begin n_fail++; $display("FAIL padding_extra: got %0d events want 0", obs_q.size()); end
    obs_q.delete();
  endtask

  task automatic test_back_to_back;
    logic [7:0] f[$];
    logic [7:0] p[$];
    int len;
    for (int fr = 0; fr < 4; fr++) begin
      len = $urandom_range(1, 13);
      p = {};
      for (int i = 0; i < len; i++) p.push_back(8'($urandom));
      build((fr % 2) ? 48'h42_04_20_42_04_20 : 48'hFFFF_FFFF_FFFF, 16'hA455, 16'(len + 8), p, f);
      run_frame(f, f.size());
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_asrt++;
      o = (obs_q.size() > 0) ? obs_q.pop_front() : '0;
      if (o !== e) begin
        n_fail++;
        $display("FAIL b2b: got kind=%0d data=%h cyc=%0d want kind=%0d data=%h cyc=%0d",
                 o.kind, o.data, o.cyc, e.kind, e.data, e.cyc);
      end
    end
    n_asrt++;
    if (obs_q.size() !== 0) begin n_fail++; $display("FAIL b2b_extra: got %0d events want 0", obs_q.size()); end
    obs_q.delete();
  endtask

  initial begin
    test_reset();
    test_filters();
    test_runt();
    test_reset_mid();
    test_padding();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
